rca_grid_lsq_arbiter: RTL and testbench

// Core-side end of rca_lsq_grid_interface (lsq modport). Accepts per-row load/store requests from the
// RCA grid and buffers them in program order in a multi-write FIFO. Issues them one at a time to the

---
 rtl/rca_grid_lsq_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_rca_grid_lsq_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_grid_lsq_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : rca_grid_lsq_arbiter                                            |
// | Purpose: Core-side end of the RCA grid load/store interface. Per-row     |
// |          requests are packed in ascending row order into a multi-write   |
// |          FIFO. They are issued one at a time to the core LS unit, and    |
// |          load data is returned to the requesting row with a one-cycle    |
// |          load_complete pulse.                                            |
// | Ports  : clk, rst (async, active-high)                                   |
// |          addr/data/fn3/load/store/new_request : flattened per-row grid   |
// |            request fields; row r occupies slice [r*W +: W]               |
// |          fifo_full      : grid must hold off new requests while high     |
// |          load_complete  : one-hot pulse to the row whose load returned   |
// |          load_data      : returned load data, valid with load_complete   |
// |          ls_req_*       : valid/ready request channel to the LS unit     |
// |          ls_rsp_*       : in-order load response from the LS unit        |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module rca_grid_lsq_arbiter #(
  parameter int GRID_NUM_ROWS = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int XLEN          = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [GRID_NUM_ROWS*XLEN-1:0] addr,
  input  logic [GRID_NUM_ROWS*XLEN-1:0] data,
  input  logic [GRID_NUM_ROWS*3-1:0]    fn3,
  input  logic [GRID_NUM_ROWS-1:0]      load,
  input  logic [GRID_NUM_ROWS-1:0]      store,
  input  logic [GRID_NUM_ROWS-1:0]      new_request,
  output logic                          fifo_full,
  output logic [GRID_NUM_ROWS-1:0]      load_complete,
  output logic [XLEN-1:0]               load_data,
  output logic                          ls_req_valid,
  input  logic                          ls_req_ready,
  output logic [XLEN-1:0]               ls_req_addr,
  output logic [XLEN-1:0]               ls_req_data,
  output logic [2:0]                    ls_req_fn3,
  output logic                          ls_req_load,
  output logic                          ls_req_store,
  input  logic                          ls_rsp_valid,
  input  logic [XLEN-1:0]               ls_rsp_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ROW_W = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1;

  // Above this occupancy a full-row burst might not fit, so the grid is stalled early.
  localparam logic [CNT_W-1:0] C_FULL_THRESH = CNT_W'(FIFO_DEPTH - GRID_NUM_ROWS);

  typedef enum logic [0:0] {
    ST_ISSUE    = 1'b0,
    ST_WAIT_RSP = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // FIFO storage; the store flag is implied by !load since only one-hot requests are kept.
  logic [XLEN-1:0]  r_mem_addr [FIFO_DEPTH];
  logic [XLEN-1:0]  r_mem_data [FIFO_DEPTH];
  logic [2:0]       r_mem_fn3  [FIFO_DEPTH];
  logic             r_mem_load [FIFO_DEPTH];
  logic [ROW_W-1:0] r_mem_row  [FIFO_DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [ROW_W-1:0] r_row;
  logic [GRID_NUM_ROWS-1:0] r_load_complete;
  logic [XLEN-1:0]  r_load_data;

  logic [GRID_NUM_ROWS-1:0] w_push;
  logic [PTR_W-1:0]         w_slot [GRID_NUM_ROWS];
  logic [CNT_W-1:0]         w_push_cnt;
  logic                     w_empty;
  logic                     w_pop;
  logic                     w_rsp_take;
  logic                     w_head_load;
  logic                     w_bad_req;

  // Rows asserting both or neither of load/store are dropped.
  assign w_push    = new_request & (load ^ store);
  assign w_bad_req = |(new_request & ~(load ^ store));
  assign w_empty   = (r_count == '0);
  assign w_head_load = r_mem_load[r_rd_ptr];

  // Each pushing row takes the next free slot after all lower-numbered pushing rows,
  // which keeps program order equal to ascending row order within a cycle.
  always_comb begin
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < GRID_NUM_ROWS; i++) begin
      w_slot[i] = r_wr_ptr + acc[PTR_W-1:0];
      if (w_push[i]) begin
        acc = acc + 1'b1;
      end
    end
    w_push_cnt = acc;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < GRID_NUM_ROWS; i++) begin
      if (w_push[i]) begin
        r_mem_addr[w_slot[i]] <= addr[i*XLEN +: XLEN];
        r_mem_data[w_slot[i]] <= data[i*XLEN +: XLEN];
        r_mem_fn3[w_slot[i]]  <= fn3[i*3 +: 3];
        r_mem_load[w_slot[i]] <= load[i];
        r_mem_row[w_slot[i]]  <= ROW_W'(i);
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_rsp_take   = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        if (!w_empty && ls_req_ready) begin
          w_pop = 1'b1;
          if (w_head_load) begin
            w_state_next = ST_WAIT_RSP;
          end
        end
      end
      ST_WAIT_RSP: begin
        if (ls_rsp_valid) begin
          w_rsp_take   = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      default: w_state_next = ST_ISSUE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ISSUE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_row           <= '0;
      r_load_complete <= '0;
      r_load_data     <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_push_cnt[PTR_W-1:0];
      r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, w_pop};
      r_count  <= r_count + w_push_cnt - {{(CNT_W-1){1'b0}}, w_pop};
      if (w_pop && w_head_load) begin
        r_row <= r_mem_row[r_rd_ptr];
      end
      r_load_complete <= '0;
      if (w_rsp_take) begin
        r_load_complete[r_row] <= 1'b1;
        r_load_data            <= ls_rsp_data;
      end
    end
  end

  assign fifo_full     = (r_count > C_FULL_THRESH);
  assign load_complete = r_load_complete;
  assign load_data     = r_load_data;

  // Head entry is presented directly; it cannot change while stalled because
  // pushes only ever write free slots.
  assign ls_req_valid = (r_state == ST_ISSUE) && !w_empty;
  assign ls_req_addr  = r_mem_addr[r_rd_ptr];
  assign ls_req_data  = r_mem_data[r_rd_ptr];
  assign ls_req_fn3   = r_mem_fn3[r_rd_ptr];
  assign ls_req_load  = ls_req_valid & w_head_load;
  assign ls_req_store = ls_req_valid & ~w_head_load;

  always @(posedge clk) begin
    if (!rst) begin
      a_req_onehot: assert (!w_bad_req)
        else $warning("rca_grid_lsq_arbiter: request with load==store dropped");
      a_no_overflow: assert (!((|w_push) && fifo_full))
        else $error("rca_grid_lsq_arbiter: request enqueued while fifo_full");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rca_grid_lsq_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_rca_grid_lsq_arbiter                                         |
// | Purpose: Self-checking bench for rca_grid_lsq_arbiter: directed scenarios|
// |          with literal expectations plus a randomized phase, all compared |
// |          every cycle against a queue-based reference model.              |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_rca_grid_lsq_arbiter;
  localparam int ROWS = 4;
  localparam int DEPTH = 8;
  localparam int XLEN = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [ROWS*XLEN-1:0] addr, data;
  logic [ROWS*3-1:0]    fn3;
  logic [ROWS-1:0]      load, store, new_request;
  logic                 fifo_full;
  logic [ROWS-1:0]      load_complete;
  logic [XLEN-1:0]      load_data;
  logic                 ls_req_valid, ls_req_ready;
  logic [XLEN-1:0]      ls_req_addr, ls_req_data;
  logic [2:0]           ls_req_fn3;
  logic                 ls_req_load, ls_req_store;
  logic                 ls_rsp_valid;
  logic [XLEN-1:0]      ls_rsp_data;

  rca_grid_lsq_arbiter #(.GRID_NUM_ROWS(ROWS), .FIFO_DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .fn3(fn3), .load(load),
    .store(store), .new_request(new_request), .fifo_full(fifo_full),
    .load_complete(load_complete), .load_data(load_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
    .ls_req_addr(ls_req_addr), .ls_req_data(ls_req_data), .ls_req_fn3(ls_req_fn3),
    .ls_req_load(ls_req_load), .ls_req_store(ls_req_store),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    logic        l;
    int          row;
  } ent_t;

  ent_t        q[$];
  ent_t        m_e;
  bit          m_wait = 0;
  int          m_row = 0;
  logic [3:0]  m_lc = '0;
  logic [31:0] m_ld = '0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_wait = 0;
      m_lc   = '0;
      m_ld   = '0;
    end else begin
      m_lc = '0;
      if (m_wait) begin
        if (ls_rsp_valid) begin
          m_lc   = 4'b0001 << m_row;
          m_ld   = ls_rsp_data;
          m_wait = 0;
        end
      end else if (q.size() > 0 && ls_req_ready) begin
        m_e = q.pop_front();
        if (m_e.l) begin
          m_wait = 1;
          m_row  = m_e.row;
        end
      end
      for (int r = 0; r < ROWS; r++) begin
        if (new_request[r] && (load[r] ^ store[r])) begin
          m_e.a = addr[r*32 +: 32];
          m_e.d = data[r*32 +: 32];
          m_e.f = fn3[r*3 +: 3];
          m_e.l = load[r];
          m_e.row = r;
          q.push_back(m_e);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic exp_valid;
    if (rst) begin
      chk("rst_valid", ls_req_valid, 0);
      chk("rst_full", fifo_full, 0);
      chk("rst_lc", load_complete, 0);
      chk("rst_ld", load_data, 0);
    end else begin
      exp_valid = !m_wait && (q.size() > 0);
      chk("req_valid", ls_req_valid, exp_valid);
      if (exp_valid) begin
        chk("req_addr", ls_req_addr, q[0].a);
        chk("req_data", ls_req_data, q[0].d);
        chk("req_fn3", ls_req_fn3, q[0].f);
        chk("req_load", ls_req_load, q[0].l);
        chk("req_store", ls_req_store, !q[0].l);
      end
      chk("fifo_full", fifo_full, q.size() > (DEPTH - ROWS));
      chk("load_complete", load_complete, m_lc);
      chk("load_data", load_data, m_ld);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int r, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, input logic l, input logic s);
    addr[r*32 +: 32] = a;
    data[r*32 +: 32] = d;
    fn3[r*3 +: 3]    = f;
    load[r]          = l;
    store[r]         = s;
    new_request[r]   = 1'b1;
  endtask

  task automatic idle();
    new_request = '0;
  endtask

  initial begin
    rst = 1'b1;
    addr = '0; data = '0; fn3 = '0; load = '0; store = '0; new_request = '0;
    ls_req_ready = 1'b0; ls_rsp_valid = 1'b0; ls_rsp_data = '0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("lit_reset_valid", ls_req_valid, 0);
    chk("lit_reset_full", fifo_full, 0);
    chk("lit_reset_lc", load_complete, 0);
    chk("lit_reset_ld", load_data, 0);

    // Load on row 0 and store on row 2 in the same cycle.
    step();
    set_row(0, 32'h100, 32'h0, 3'b010, 1'b1, 1'b0);
    set_row(2, 32'h200, 32'h55, 3'b010, 1'b0, 1'b1);
    ls_req_ready = 1'b1;
    step(); idle();
    @(negedge clk);
    chk("lit_t1_valid", ls_req_valid, 1);
    chk("lit_t1_addr", ls_req_addr, 32'h100);
    chk("lit_t1_load", ls_req_load, 1);
    step();
    ls_rsp_valid = 1'b1; ls_rsp_data = 32'hDEAD;
    @(negedge clk);
    chk("lit_t1_wait_valid", ls_req_valid, 0);
    step();
    ls_rsp_valid = 1'b0;
    @(negedge clk);
    chk("lit_t1_lc", load_complete, 4'b0001);
    chk("lit_t1_ld", load_data, 32'hDEAD);
    chk("lit_t1_st_addr", ls_req_addr, 32'h200);
    chk("lit_t1_st_store", ls_req_store, 1);
    step();
    @(negedge clk);
    chk("lit_t1_no_pulse", load_complete, 0);

    // Two full-row store bursts while stalled, then drain.
    step();
    ls_req_ready = 1'b0;
    for (int r = 0; r < ROWS; r++) set_row(r, 32'h1000 + r*4, r, 3'b010, 1'b0, 1'b1);
    step(); idle();
    @(negedge clk);
    chk("lit_t2_full_at4", fifo_full, 0);
    step();
    for (int r = 0; r < ROWS; r++) set_row(r, 32'h2000 + r*4, 32'h10 + r, 3'b001, 1'b0, 1'b1);
    step(); idle();
    @(negedge clk);
    chk("lit_t2_full_at8", fifo_full, 1);
    chk("lit_t2_head", ls_req_addr, 32'h1000);
    step();
    ls_req_ready = 1'b1;
    repeat (12) step();
    @(negedge clk);
    chk("lit_t2_drained", ls_req_valid, 0);

    // Row 1 with load and store both set is dropped.
    step();
    set_row(1, 32'h300, 32'h1, 3'b010, 1'b1, 1'b1);
    step(); idle();
    @(negedge clk);
    chk("lit_t4_valid", ls_req_valid, 0);
    chk("lit_t4_full", fifo_full, 0);

    // Simultaneous push of a full burst and pop at maximum legal occupancy.
    step();
    ls_req_ready = 1'b0;
    for (int r = 0; r < ROWS; r++) set_row(r, 32'h4000 + r*4, 32'h40 + r, 3'b000, 1'b0, 1'b1);
    step(); idle();
    step();
    ls_req_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) set_row(r, 32'h5000 + r*4, 32'h50 + r, 3'b100, 1'b0, 1'b1);
    step(); idle();
    ls_req_ready = 1'b0;
    @(negedge clk);
    chk("lit_t6_full_at7", fifo_full, 1);
    chk("lit_t6_head", ls_req_addr, 32'h4004);
    step();
    ls_req_ready = 1'b1;
    repeat (10) step();

    // Reset while a load is outstanding; the late response must be ignored.
    set_row(3, 32'h600, 32'h0, 3'b100, 1'b1, 1'b0);
    step(); idle();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("lit_t5_rst_valid", ls_req_valid, 0);
    step();
    rst = 1'b0;
    ls_rsp_valid = 1'b1; ls_rsp_data = 32'hBEEF;
    step();
    ls_rsp_valid = 1'b0;
    @(negedge clk);
    chk("lit_t5_lc", load_complete, 0);
    chk("lit_t5_ld", load_data, 0);
    chk("lit_t5_valid", ls_req_valid, 0);

    // Randomized mixed traffic with random stalls and stray responses.
    for (int c = 0; c < 400; c++) begin
      step();
      ls_req_ready = ($urandom_range(0, 2) != 0);
      ls_rsp_valid = ($urandom_range(0, 3) == 0);
      ls_rsp_data  = $urandom;
      idle();
      if (q.size() <= (DEPTH - ROWS)) begin
        for (int r = 0; r < ROWS; r++) begin
          if ($urandom_range(0, 3) == 0) begin
            logic l;
            l = 1'($urandom_range(0, 1));
            set_row(r, $urandom, $urandom, 3'($urandom_range(0, 7)), l, !l);
          end
        end
      end
    end
    step();
    idle();
    ls_req_ready = 1'b1;
    ls_rsp_valid = 1'b1;
    repeat (40) step();
    @(negedge clk);
    chk("final_drained", ls_req_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
